// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg: shared widths, FSM state encodings and PE bound-level codes
// for the convolution PE issue-side sequencer.
package pe_feeder_pkg;

    localparam int CELL_BIT = 8;   // bits per cell
    localparam int N_CELL   = 9;   // cells per beat (3x3 window)
    localparam int BIAS_W   = 16;  // bias width

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Bound-level encodings understood by the PE
    localparam logic [2:0] BOUND_L0 = 3'd0;
    localparam logic [2:0] BOUND_L1 = 3'd1;
    localparam logic [2:0] BOUND_L2 = 3'd2;
    localparam logic [2:0] BOUND_L3 = 3'd3;
    localparam logic [2:0] BOUND_L4 = 3'd4;
    localparam logic [2:0] BOUND_L5 = 3'd5;

endpackage

// File: rtl/pe_group_buf.sv
// pe_group_buf: one-group beat buffer for pe_feeder.
// DEPTH x W register file, one write port and one asynchronous read port.
// Data is not reset; validity is tracked by the owner's counters.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data ({in, weight})
//   raddr  : read address
//   rdata  : read data (combinational)
module pe_group_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 144,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: buffers one accumulation group of input/weight beats and then
// drives the PE with en held high for step+1 unbroken cycles. Counts PE
// out_en pulses so the controller can tell when all issued groups are done.
//   cfg_*      : per-group descriptor (step, bound level, bias), ready/valid
//   s_*        : 72-bit input/weight beat stream, ready/valid
//   pe_*       : registered PE drive (in, weight, bias, step, bound, en)
//   pe_out_en  : PE output-valid pulse
//   pending    : groups issued but not yet answered
//   idle       : nothing buffered, nothing outstanding
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int CB        = CELL_BIT,
    parameter int NC        = N_CELL,
    parameter int BW        = BIAS_W,
    parameter int MAX_BEATS = 8,
    parameter int MAX_PEND  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_step,
    input  logic [2:0]         cfg_bound,
    input  logic [BW-1:0]      cfg_bias,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CB*NC-1:0]   s_in,
    input  logic [CB*NC-1:0]   s_weight,
    output logic [CB*NC-1:0]   pe_in,
    output logic [CB*NC-1:0]   pe_weight,
    output logic [BW-1:0]      pe_bias,
    output logic [2:0]         pe_step,
    output logic [2:0]         pe_bound_level,
    output logic               pe_en,
    input  logic               pe_out_en,
    output logic [1:0]         pending,
    output logic               idle
);

    localparam int         DW         = CB * NC;
    localparam int         AW         = $clog2(MAX_BEATS);
    localparam logic [1:0] MAX_PEND_V = 2'(MAX_PEND);

    logic [1:0]    state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [2:0]    bound_q, bound_d;
    logic [BW-1:0] bias_q, bias_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    pending_q, pending_d;

    logic [DW-1:0] pe_in_q, pe_in_d;
    logic [DW-1:0] pe_weight_q, pe_weight_d;
    logic [BW-1:0] pe_bias_q, pe_bias_d;
    logic [2:0]    pe_step_q, pe_step_d;
    logic [2:0]    pe_bound_q, pe_bound_d;
    logic          pe_en_q, pe_en_d;

    logic          cfg_hs, s_hs, last_issue;
    logic [AW-1:0] raddr;
    logic [2*DW-1:0] rdata;

    assign cfg_ready  = (state_q == ST_IDLE) && (pending_q < MAX_PEND_V);
    assign s_ready    = (state_q == ST_FILL);
    assign cfg_hs     = cfg_valid && cfg_ready;
    assign s_hs       = s_valid && s_ready;
    assign last_issue = (state_q == ST_ISSUE) && (rcnt_q == AW'(step_q));

    // The PE registers are loaded one beat ahead of the ISSUE cycle that shows
    // them, so during FILL the read port looks at beat 0 and during ISSUE it
    // looks at the beat after the one currently on the outputs.
    assign raddr = (state_q == ST_ISSUE) ? rcnt_q + AW'(1) : '0;

    pe_group_buf #(
        .DEPTH (MAX_BEATS),
        .W     (2 * DW),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (s_hs),
        .waddr (wcnt_q),
        .wdata ({s_in, s_weight}),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        bound_d     = bound_q;
        bias_d      = bias_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        pe_step_d   = pe_step_q;
        pe_bound_d  = pe_bound_q;
        pe_en_d     = 1'b0;
        pe_in_d     = '0;
        pe_weight_d = '0;
        pe_bias_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    step_d     = cfg_step;
                    bound_d    = cfg_bound;
                    bias_d     = cfg_bias;
                    pe_step_d  = cfg_step;
                    pe_bound_d = cfg_bound;
                    wcnt_d     = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (s_hs) begin
                    wcnt_d = wcnt_q + AW'(1);
                    if (wcnt_q == AW'(step_q)) begin
                        state_d   = ST_ISSUE;
                        rcnt_d    = '0;
                        pe_en_d   = 1'b1;
                        pe_bias_d = bias_q;
                        // A one-beat group has beat 0 arriving right now,
                        // not yet in the buffer.
                        if (step_q == 3'd0) begin
                            pe_in_d     = s_in;
                            pe_weight_d = s_weight;
                        end else begin
                            pe_in_d     = rdata[2*DW-1:DW];
                            pe_weight_d = rdata[DW-1:0];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (last_issue) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d      = rcnt_q + AW'(1);
                    pe_en_d     = 1'b1;
                    pe_in_d     = rdata[2*DW-1:DW];
                    pe_weight_d = rdata[DW-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion and retirement in the same cycle cancel out; a stray
    // out_en with nothing outstanding is dropped.
    always_comb begin
        pending_d = pending_q;
        if (last_issue && !(pe_out_en && pending_q != 2'd0)) begin
            pending_d = pending_q + 2'd1;
        end else if (!last_issue && pe_out_en && pending_q != 2'd0) begin
            pending_d = pending_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            bound_q     <= '0;
            bias_q      <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            pending_q   <= '0;
            pe_in_q     <= '0;
            pe_weight_q <= '0;
            pe_bias_q   <= '0;
            pe_step_q   <= '0;
            pe_bound_q  <= '0;
            pe_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            bound_q     <= bound_d;
            bias_q      <= bias_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            pending_q   <= pending_d;
            pe_in_q     <= pe_in_d;
            pe_weight_q <= pe_weight_d;
            pe_bias_q   <= pe_bias_d;
            pe_step_q   <= pe_step_d;
            pe_bound_q  <= pe_bound_d;
            pe_en_q     <= pe_en_d;
        end
    end

    assign pe_in          = pe_in_q;
    assign pe_weight      = pe_weight_q;
    assign pe_bias        = pe_bias_q;
    assign pe_step        = pe_step_q;
    assign pe_bound_level = pe_bound_q;
    assign pe_en          = pe_en_q;
    assign pending        = pending_q;
    assign idle           = (state_q == ST_IDLE) && (pending_q == 2'd0);

endmodule

// File: tb/tb_pe_feeder.sv
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_step;
    logic [2:0]  cfg_bound;
    logic [15:0] cfg_bias;
    logic        s_valid;
    logic        s_ready;
    logic [71:0] s_in;
    logic [71:0] s_weight;
    logic [71:0] pe_in;
    logic [71:0] pe_weight;
    logic [15:0] pe_bias;
    logic [2:0]  pe_step;
    logic [2:0]  pe_bound_level;
    logic        pe_en;
    logic        pe_out_en;
    logic [1:0]  pending;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;
    int exp_pend = 0;

    pe_feeder dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_step       (cfg_step),
        .cfg_bound      (cfg_bound),
        .cfg_bias       (cfg_bias),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_in           (s_in),
        .s_weight       (s_weight),
        .pe_in          (pe_in),
        .pe_weight      (pe_weight),
        .pe_bias        (pe_bias),
        .pe_step        (pe_step),
        .pe_bound_level (pe_bound_level),
        .pe_en          (pe_en),
        .pe_out_en      (pe_out_en),
        .pending        (pending),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] mk(input int g, input int i, input int w);
        logic [71:0] v;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(g * 16 + i * 2 + w) ^ 8'(k * 17);
        return v;
    endfunction

    // Sends one descriptor and its beats, then checks the issued group.
    task automatic run_group(input int g, input int step, input int bound,
                             input logic [15:0] bias, input int gap, input int outen_last);
        int t;
        int fill_cnt;
        t = 0;
        fill_cnt = 0;
        cfg_valid = 1'b1;
        cfg_step  = 3'(step);
        cfg_bound = 3'(bound);
        cfg_bias  = bias;
        while (!cfg_ready && t < 20) begin cyc(); t++; end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL g%0d cfg_wait: cfg_ready got %b need 1", g, cfg_ready);
        end
        cyc();
        cfg_valid = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL g%0d s_ready_after_cfg: got %b need 1", g, s_ready);
        end
        for (int i = 0; i <= step; i++) begin
            s_valid  = 1'b1;
            s_in     = mk(g, i, 0);
            s_weight = mk(g, i, 1);
            if (s_ready) fill_cnt++;
            cyc();
            if (gap != 0 && i < step) begin
                s_valid = 1'b0;
                if (s_ready) fill_cnt++;
                cyc();
            end
        end
        s_valid  = 1'b0;
        s_in     = '0;
        s_weight = '0;
        n_cmp++;
        if (fill_cnt !== step + 1 + (gap != 0 ? step : 0)) begin
            n_err++;
            $display("FAIL g%0d fill_len: got %0d need %0d", g, fill_cnt, step + 1 + (gap != 0 ? step : 0));
        end
        for (int i = 0; i <= step; i++) begin
            n_cmp++;
            if (pe_en !== 1'b1 || pe_in !== mk(g, i, 0) || pe_weight !== mk(g, i, 1)) begin
                n_err++;
                $display("FAIL g%0d beat%0d: en=%b in=%h w=%h need en=1 in=%h w=%h",
                         g, i, pe_en, pe_in, pe_weight, mk(g, i, 0), mk(g, i, 1));
            end
            n_cmp++;
            if (pe_bias !== ((i == 0) ? bias : 16'h0)) begin
                n_err++;
                $display("FAIL g%0d bias%0d: got %h need %h", g, i, pe_bias, (i == 0) ? bias : 16'h0);
            end
            n_cmp++;
            if (pe_step !== 3'(step) || pe_bound_level !== 3'(bound)) begin
                n_err++;
                $display("FAIL g%0d cfg_fwd%0d: step=%0d bound=%0d need %0d %0d",
                         g, i, pe_step, pe_bound_level, step, bound);
            end
            if (outen_last != 0 && i == step) pe_out_en = 1'b1;
            cyc();
            pe_out_en = 1'b0;
        end
        if (!(outen_last != 0 && exp_pend > 0)) exp_pend++;
        n_cmp++;
        if (pe_en !== 1'b0 || pe_bias !== 16'h0 || pe_in !== 72'h0) begin
            n_err++;
            $display("FAIL g%0d after_issue: en=%b bias=%h in=%h need zeros", g, pe_en, pe_bias, pe_in);
        end
        n_cmp++;
        if (pending !== 2'(exp_pend) || cfg_ready !== (exp_pend < 3)) begin
            n_err++;
            $display("FAIL g%0d pend_after: pending=%0d cfg_ready=%b need %0d %b",
                     g, pending, cfg_ready, exp_pend, exp_pend < 3);
        end
    endtask

    task automatic pulse_out();
        pe_out_en = 1'b1;
        cyc();
        pe_out_en = 1'b0;
        if (exp_pend > 0) exp_pend--;
        n_cmp++;
        if (pending !== 2'(exp_pend) || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL out_pulse: pending=%0d cfg_ready=%b need %0d 1", pending, cfg_ready, exp_pend);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_step = '0; cfg_bound = '0; cfg_bias = '0;
        s_valid = 1'b0; s_in = '0; s_weight = '0; pe_out_en = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        n_cmp++;
        if (pe_en !== 1'b0 || pe_in !== 72'h0 || pe_weight !== 72'h0 || pe_bias !== 16'h0 ||
            pe_step !== 3'd0 || pe_bound_level !== 3'd0 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b in=%h w=%h bias=%h step=%0d bound=%0d s_ready=%b need zeros",
                     pe_en, pe_in, pe_weight, pe_bias, pe_step, pe_bound_level, s_ready);
        end
        n_cmp++;
        if (pending !== 2'd0 || idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: pending=%0d idle=%b need 0 1", pending, idle);
        end
    endtask

    task automatic test_basic();
        run_group(1, 2, 1, 16'h0010, 0, 0);
        pulse_out();
    endtask

    task automatic test_gap_fill();
        run_group(2, 7, 3, 16'h1234, 1, 0);
        pulse_out();
        pulse_out();   // stray out_en with nothing outstanding
    endtask

    task automatic test_pending_limit();
        run_group(3, 0, 2, 16'h0001, 0, 0);
        run_group(4, 0, 2, 16'h0002, 0, 0);
        run_group(5, 0, 2, 16'h0003, 0, 0);
        cfg_valid = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (cfg_ready !== 1'b0 || pending !== 2'd3 || idle !== 1'b0 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pend_full: cfg_ready=%b pending=%0d idle=%b s_ready=%b need 0 3 0 0",
                     cfg_ready, pending, idle, s_ready);
        end
        cfg_valid = 1'b0;
        pulse_out();
    endtask

    task automatic test_coincident_out_en();
        pulse_out();
        run_group(6, 1, 4, 16'h0042, 0, 1);
    endtask

    task automatic test_mid_issue_reset();
        cfg_valid = 1'b1; cfg_step = 3'd3; cfg_bound = 3'd5; cfg_bias = 16'h0077;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_in = mk(7, i, 0); s_weight = mk(7, i, 1);
            cyc();
        end
        s_valid = 1'b0;
        cyc();
        n_cmp++;
        if (pe_en !== 1'b1 || pe_in !== mk(7, 1, 0)) begin
            n_err++;
            $display("FAIL rst_issue2: en=%b in=%h need 1 %h", pe_en, pe_in, mk(7, 1, 0));
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_pend = 0;
        n_cmp++;
        if (pe_en !== 1'b0 || pe_in !== 72'h0 || pe_weight !== 72'h0 || pe_bias !== 16'h0 ||
            pe_step !== 3'd0 || pe_bound_level !== 3'd0) begin
            n_err++;
            $display("FAIL rst_outputs: en=%b in=%h w=%h bias=%h step=%0d bound=%0d need zeros",
                     pe_en, pe_in, pe_weight, pe_bias, pe_step, pe_bound_level);
        end
        n_cmp++;
        if (pending !== 2'd0 || idle !== 1'b1) begin
            n_err++;
            $display("FAIL rst_state: pending=%0d idle=%b need 0 1", pending, idle);
        end
        cyc();
        n_cmp++;
        if (pe_en !== 1'b0 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_partial: en=%b s_ready=%b need 0 0", pe_en, s_ready);
        end
        run_group(8, 1, 0, 16'h00a5, 0, 0);
        pulse_out();
    endtask

    task automatic test_neg_bias_single();
        run_group(9, 0, 1, 16'h8000, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap_fill();
        test_pending_limit();
        test_coincident_out_en();
        test_mid_issue_reset();
        test_neg_bias_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Issue-side sequencer for the convolution PE. It accepts a per-group job descriptor (step count, bound level, bias) and a ready/valid stream of 72-bit input/weight beats. It buffers one complete accumulation group and then drives the PE's `in`, `weight`, `bias`, `step`, `bound_level` and `en` ports with `en` held high for exactly step+1 consecutive cycles. This matters because the PE's multi-cycle accumulator drops partial sums whenever `en` falls mid-group. The block also counts the PE's `out_en` pulses so the controller knows when every issued group has produced its output.

## Interface
- CELL_BIT, 8, bits per cell
- N_CELL, 9, cells per beat (3x3 window)
- BIAS_W, 16, bias width
- MAX_BEATS, 8, buffer depth; equals max step+1
- MAX_PEND, 3, max groups issued but not yet answered by pe_out_en
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- cfg_valid  input  1  descriptor valid
- cfg_ready  output  1  descriptor accepted when high with cfg_valid
- cfg_step  input  3  beats per group minus 1
- cfg_bound  input  3  bound level forwarded to PE
- cfg_bias  input  BIAS_W  signed bias for the group
- s_valid  input  1  beat valid
- s_ready  output  1  beat accepted when high with s_valid
- s_in  input  CELL_BIT*N_CELL  input cells
- s_weight  input  CELL_BIT*N_CELL  weight cells
- pe_in, pe_weight  output  CELL_BIT*N_CELL  to PE
- pe_bias  output  BIAS_W  to PE
- pe_step, pe_bound_level  output  3  to PE
- pe_en  output  1  to PE
- pe_out_en  input  1  PE output-valid pulse
- pending  output  2  groups awaiting pe_out_en
- idle  output  1  state IDLE and pending==0

## Operation
- States: IDLE, FILL, ISSUE.
- IDLE:
  - cfg_ready = (pending < MAX_PEND); s_ready = 0.
  - On a cfg handshake, latch step, bound and bias, clear the write counter, and go to FILL.
- FILL:
  - s_ready = 1; cfg_ready = 0.
  - Each s handshake writes buf[wcnt] and increments wcnt.
  - The handshake with wcnt == step_r goes to ISSUE and clears rcnt.
- ISSUE:
  - s_ready = 0; cfg_ready = 0.
  - Each cycle, register pe_in/pe_weight = buf[rcnt], pe_en = 1, and increment rcnt.
  - When rcnt == step_r: increment pending and go to IDLE.
- pe_bias = bias_r on the beat with rcnt == 0, and 0 on every other beat. Bias enters the accumulation exactly once.
- pe_step and pe_bound_level are registered from step_r/bound_r. They update only on a cfg handshake and are held constant through the whole group.
- When pe_en = 0, pe_in, pe_weight and pe_bias are 0.
- pending:
  - +1 on the last issue beat; −1 on pe_out_en.
  - Both events in the same cycle: unchanged.
  - pe_out_en with pending == 0 is ignored; pending saturates at 0.
- No data transform; beats pass through bit-exact.

## Timing
- All outputs to the PE are registered.
- Reset values: every output is 0, state is IDLE, pending is 0, and idle is 1 from the first cycle after reset is sampled.
- Reset mid-FILL or mid-ISSUE: buffer contents are discarded. pe_en is 0 the cycle after reset is sampled. No partial group is ever issued.
- Cfg handshake at edge T: state is FILL from T+1, and s_ready is high in cycle T+1.
- Last beat handshake at edge T: pe_en is high in cycles T+1 … T+1+step_r, with no gaps.
- cfg_ready returns high in the cycle after the last pe_en cycle, provided pending < MAX_PEND.
- Minimum group period is 1 + 2·(step+1) cycles.
- step = 0: one beat, one pe_en cycle, and pe_bias = bias on that cycle.
- s_valid deasserting during FILL only stretches FILL. Issue is never stalled.

## Structure
- The shared package holds:
  - the default widths CELL_BIT, N_CELL, BIAS_W;
  - the state enum (IDLE/FILL/ISSUE);
  - the bound-level encodings 0–5 used by the PE.
- One natural sub-module: `pe_group_buf`. It is a MAX_BEATS × 2·CELL_BIT·N_CELL register file with one write port (wcnt) and one read port (rcnt). It has no reset on its data; only the counters reset.

## Test plan
- step=2, bound=1, bias=0x0010, beats A,B,C sent back-to-back:
  - pe_en is high for exactly 3 consecutive cycles carrying A,B,C.
  - pe_bias is 0x0010 on A only.
  - pe_step is 2 and pe_bound_level is 1 throughout; pending goes 0→1.
- step=7, s_valid toggling every other cycle:
  - FILL lasts 15 cycles.
  - pe_en is high for 8 unbroken cycles in buffer order.
- Three groups with step=0 and no pe_out_en:
  - pending = 3, and cfg_ready stays low in IDLE.
  - One pe_out_en pulse brings pending to 2 and cfg_ready high the next cycle.
- pe_out_en coincident with the last issue beat of a new group (pending = 1): pending stays 1.
- reset asserted on the 2nd ISSUE cycle of a step=3 group:
  - pe_en is 0 on the next cycle and all outputs are 0.
  - pending = 0 and idle = 1.
  - A following group issues cleanly.
- step=0, bias=0x8000 (most negative): a single pe_en cycle with pe_bias = 0x8000, and pe_bias is 0 the next cycle.
